ps2_key_tracker: RTL

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_key_tracker_if.sv | 24 ++
 rtl/ps2_rx.sv | 87 ++++++++
 rtl/ps2_key_tracker.sv | 105 ++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared decoder state encoding, scan-code prefixes and the
//               default tracked-key table for the PS/2 key tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    localparam logic [7:0] c_prefix_ext = 8'hE0;
    localparam logic [7:0] c_prefix_brk = 8'hF0;

    localparam logic [8:0] c_key_up    = 9'h175;
    localparam logic [8:0] c_key_down  = 9'h172;
    localparam logic [8:0] c_key_left  = 9'h16B;
    localparam logic [8:0] c_key_right = 9'h174;
    localparam logic [8:0] c_key_s     = 9'h01B;

    // Index 0 sits in the least significant nine bits.
    localparam logic [44:0] c_default_key_codes =
        {c_key_s, c_key_right, c_key_left, c_key_down, c_key_up};

endpackage
`default_nettype wire

// File: rtl/ps2_key_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_tracker_if
// Description : Key-event and key-state bundle produced by the PS/2 tracker.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_key_tracker_if #(
    parameter int NUM_KEYS = 5
);
    logic [NUM_KEYS-1:0] key_state;
    logic                event_valid;
    logic                event_make;
    logic [8:0]          event_code;
    logic                frame_err;

    modport master (
        output key_state, event_valid, event_make, event_code, frame_err
    );

    modport slave (
        input  key_state, event_valid, event_make, event_code, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 frame receiver: synchroniser, falling-edge detect, bit
//               counter, mid-frame timeout and frame check. Odd parity over
//               bits 1..9 is enforced only when PS2_PARITY_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_kb_clock,
    input  logic       i_kb_data,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_byte_err
);

    localparam int                c_to_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

    logic [1:0]        r_clk_sync;
    logic [1:0]        r_dat_sync;
    logic              r_clk_prev;
    logic [3:0]        r_bit_cnt;
    logic [9:0]        r_shift;
    logic [c_to_w-1:0] r_to_cnt;

    logic w_fall;
    logic w_stop_edge;
    logic w_parity_ok;
    logic w_frame_ok;

    assign w_fall      = r_clk_prev & ~r_clk_sync[1];
    assign w_stop_edge = w_fall && (r_bit_cnt == 4'd10);

`ifdef PS2_PARITY_CHECK_EN
    assign w_parity_ok = ^r_shift[9:1];
`else
    assign w_parity_ok = 1'b1;
`endif

    // r_shift[0] holds the start bit once ten bits have been shifted in.
    assign w_frame_ok   = ~r_shift[0] & r_dat_sync[1] & w_parity_ok;
    assign o_byte_valid = w_stop_edge & w_frame_ok;
    assign o_byte_err   = w_stop_edge & ~w_frame_ok;
    assign o_byte_data  = r_shift[8:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 10'd0;
            r_to_cnt   <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_kb_clock};
            r_dat_sync <= {r_dat_sync[0], i_kb_data};
            r_clk_prev <= r_clk_sync[1];

            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= 4'd0;
                end else begin
                    r_shift   <= {r_dat_sync[1], r_shift[9:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (r_bit_cnt != 4'd0) begin
                // A stalled frame is silently abandoned.
                if (r_to_cnt == c_to_last) begin
                    r_bit_cnt <= 4'd0;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_tracker
// Description : PS/2 scan-code decoder tracking held keys from a table of
//               {ext, code} entries. Parity checking via PS2_PARITY_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int                      NUM_KEYS       = 5,
    parameter logic [NUM_KEYS*9-1:0]   KEY_CODES      = c_default_key_codes,
    parameter int                      TIMEOUT_CYCLES = 50000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               kb_clock,
    input  logic               kb_data,
    ps2_key_tracker_if.master  evt
);

    logic       w_byte_valid;
    logic       w_byte_err;
    logic [7:0] w_byte;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk          (clock),
        .rst          (reset),
        .i_kb_clock   (kb_clock),
        .i_kb_data    (kb_data),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte),
        .o_byte_err   (w_byte_err)
    );

    dec_state_t          r_state;
    logic [NUM_KEYS-1:0] r_key_state;
    logic                r_event_valid;
    logic                r_event_make;
    logic [8:0]          r_event_code;
    logic                r_frame_err;

    dec_state_t w_next_state;
    logic       w_emit;
    logic       w_make;
    logic [8:0] w_code;

    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        w_make       = (r_state == ST_IDLE) || (r_state == ST_EXT);
        w_code       = {(r_state == ST_EXT) || (r_state == ST_EXT_BRK), w_byte};
        // E0 only advances from IDLE; in EXT/BRK it is absorbed, in EXT_BRK it is data.
        if (w_byte == c_prefix_ext && r_state != ST_EXT_BRK) begin
            if (r_state == ST_IDLE) begin
                w_next_state = ST_EXT;
            end
        end else if (w_byte == c_prefix_brk &&
                     (r_state == ST_IDLE || r_state == ST_EXT)) begin
            w_next_state = (r_state == ST_IDLE) ? ST_BRK : ST_EXT_BRK;
        end else begin
            w_emit       = 1'b1;
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_key_state   <= '0;
            r_event_valid <= 1'b0;
            r_event_make  <= 1'b0;
            r_event_code  <= 9'd0;
            r_frame_err   <= 1'b0;
        end else begin
            r_event_valid <= 1'b0;
            r_frame_err   <= w_byte_err;
            if (w_byte_err) begin
                r_state <= ST_IDLE;
            end else if (w_byte_valid) begin
                r_state <= w_next_state;
                if (w_emit) begin
                    r_event_valid <= 1'b1;
                    r_event_make  <= w_make;
                    r_event_code  <= w_code;
                    for (int i = 0; i < NUM_KEYS; i++) begin
                        if (w_code == KEY_CODES[9*i +: 9]) begin
                            r_key_state[i] <= w_make;
                        end
                    end
                end
            end
        end
    end

    assign evt.key_state   = r_key_state;
    assign evt.event_valid = r_event_valid;
    assign evt.event_make  = r_event_make;
    assign evt.event_code  = r_event_code;
    assign evt.frame_err   = r_frame_err;

endmodule
`default_nettype wire
